// File: rtl/kd_pkg.sv
// ---------------------------------------------------------------------------
// kd_pkg
// Shared definitions for the k-d tree clustering engine (distance unit,
// cluster compare elements, tree logic).
//   - width helpers derived from the point dimension and coordinate range
//   - default widths for dim = 3, data_range = 255
//   - coord_extract(): pulls coordinate idx out of an LSB-first packed vector
// ---------------------------------------------------------------------------
package kd_pkg;

    // Upper bounds for the generic extract helper; callers zero-extend
    // their packed vectors to VEC_MAX_W and truncate the result.
    localparam int COORD_MAX_W = 32;
    localparam int VEC_MAX_W   = 1024;

    function automatic int get_dim_size(input int data_range);
        return $clog2(data_range);
    endfunction

    function automatic int get_center_size(input int dim, input int data_range);
        return dim * $clog2(data_range);
    endfunction

    function automatic int get_dist_size(input int dim, input int data_range);
        return $clog2(data_range * dim);
    endfunction

    function automatic int get_axis_size(input int dim);
        return $clog2(dim);
    endfunction

    // Defaults for the standard engine configuration.
    localparam int DIM_DEFAULT        = 3;
    localparam int DATA_RANGE_DEFAULT = 255;
    localparam int DIM_SIZE           = get_dim_size(DATA_RANGE_DEFAULT);
    localparam int CENTER_SIZE        = get_center_size(DIM_DEFAULT, DATA_RANGE_DEFAULT);
    localparam int DIST_SIZE          = get_dist_size(DIM_DEFAULT, DATA_RANGE_DEFAULT);
    localparam int AXIS_SIZE          = get_axis_size(DIM_DEFAULT);

    // Coordinate idx occupies vec[idx*width +: width]; coordinate 0 is in
    // the LSBs.
    function automatic logic [COORD_MAX_W-1:0] coord_extract(
        input logic [VEC_MAX_W-1:0] vec,
        input int                   idx,
        input int                   width
    );
        logic [VEC_MAX_W-1:0]   shifted;
        logic [COORD_MAX_W-1:0] mask;
        shifted = vec >> (idx * width);
        mask    = {COORD_MAX_W{1'b1}} >> (COORD_MAX_W - width);
        return shifted[COORD_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/manhattan_distance_abs_diff.sv
// ---------------------------------------------------------------------------
// abs_diff
// Combinational |a - b| for unsigned operands, computed as larger minus
// smaller so the result always fits in the operand width.
// Ports:
//   a_i    in   width   unsigned operand
//   b_i    in   width   unsigned operand
//   y_o    out  width   absolute difference
// ---------------------------------------------------------------------------
module abs_diff #(
    parameter int width = 8
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    output logic [width-1:0] y_o
);

    assign y_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

endmodule

// File: rtl/manhattan_distance.sv
// ---------------------------------------------------------------------------
// manhattan_distance
// Two-stage pipelined L1 distance between a query point and a cluster
// center, plus the absolute distance along one selected split axis.
// Runs continuously; dst_done flags that the outputs belong to the inputs
// currently applied.
//
// Build option: define MANHATTAN_AXIS_DST_EN to compute axis_dst; without
// it the axis mux and its registers are absent and axis_dst reads 0.
//
// Ports:
//   clk       in   1            clock, rising edge
//   rst       in   1            asynchronous reset, active low
//   axis      in   axis_size    selected split axis (>= dim gives axis_dst 0)
//   point     in   center_size  query point, coordinate 0 in LSBs
//   center    in   center_size  cluster center, same packing
//   dst       out  dist_size    sum of |point_i - center_i|
//   axis_dst  out  dim_size     |point_axis - center_axis|
//   dst_done  out  1            outputs correspond to the current inputs
// ---------------------------------------------------------------------------
module manhattan_distance
    import kd_pkg::*;
#(
    parameter int dim        = 3,
    parameter int data_range = 255
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [get_axis_size(dim)-1:0]              axis,
    input  logic [get_center_size(dim, data_range)-1:0] point,
    input  logic [get_center_size(dim, data_range)-1:0] center,
    output logic [get_dist_size(dim, data_range)-1:0]  dst,
    output logic [get_dim_size(data_range)-1:0]        axis_dst,
    output logic                                       dst_done
);

    localparam int dim_size    = get_dim_size(data_range);
    localparam int center_size = get_center_size(dim, data_range);
    localparam int dist_size   = get_dist_size(dim, data_range);
    localparam int axis_size   = get_axis_size(dim);
    localparam int in_size     = axis_size + 2 * center_size;

    // ---------------------------------------------------------------
    // Per-coordinate absolute differences (feed Stage A)
    // ---------------------------------------------------------------
    logic [dim_size-1:0] diff_d [dim];

    for (genvar g = 0; g < dim; g++) begin : g_coord
        logic [dim_size-1:0] pt_coord;
        logic [dim_size-1:0] ct_coord;

        assign pt_coord = dim_size'(coord_extract(VEC_MAX_W'(point), g, dim_size));
        assign ct_coord = dim_size'(coord_extract(VEC_MAX_W'(center), g, dim_size));

        abs_diff #(
            .width (dim_size)
        ) u_abs_diff (
            .a_i (pt_coord),
            .b_i (ct_coord),
            .y_o (diff_d[g])
        );
    end

    // ---------------------------------------------------------------
    // Stage A: differences, input snapshot and primed flag
    // ---------------------------------------------------------------
    logic [dim_size-1:0] diff_q [dim];
    logic [in_size-1:0]  in_d;
    logic [in_size-1:0]  in_q;
    logic                primed_q;

    assign in_d = {axis, point, center};

    // NOTE: every pipeline register, including the difference array, is
    // cleared by reset so stale results can never be flagged as done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < dim; i++) begin
                diff_q[i] <= '0;
            end
            in_q     <= '0;
            primed_q <= 1'b0;
        end else begin
            for (int i = 0; i < dim; i++) begin
                diff_q[i] <= diff_d[i];
            end
            in_q     <= in_d;
            primed_q <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Stage B: sum, done flag
    // ---------------------------------------------------------------
    logic [dist_size-1:0] sum_d;
    logic                 done_d;
    logic [dist_size-1:0] dst_q;
    logic                 done_q;

    // NOTE: combinational accumulation uses blocking assignments and
    // starts from a default so no latch is inferred.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < dim; i++) begin
            sum_d = sum_d + dist_size'(diff_q[i]);
        end
    end

    // Done only once the snapshot in Stage A matches what is applied now,
    // i.e. the value entering Stage B was computed from these inputs.
    assign done_d = primed_q && (in_d == in_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dst_q  <= '0;
            done_q <= 1'b0;
        end else begin
            dst_q  <= sum_d;
            done_q <= done_d;
        end
    end

    assign dst      = dst_q;
    assign dst_done = done_q;

`ifdef MANHATTAN_AXIS_DST_EN
    // ---------------------------------------------------------------
    // Selected-axis difference: a mux over the existing abs_diff
    // outputs; out-of-range axis selects 0.
    // ---------------------------------------------------------------
    logic [dim_size-1:0] axis_diff_d;
    logic [dim_size-1:0] axis_diff_q;
    logic [dim_size-1:0] axis_dst_q;

    always_comb begin
        axis_diff_d = '0;
        for (int i = 0; i < dim; i++) begin
            if (int'(axis) == i) begin
                axis_diff_d = diff_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            axis_diff_q <= '0;
            axis_dst_q  <= '0;
        end else begin
            axis_diff_q <= axis_diff_d;
            axis_dst_q  <= axis_diff_q;
        end
    end

    assign axis_dst = axis_dst_q;
`else
    assign axis_dst = '0;
`endif

endmodule

// File: tb/tb_manhattan_distance.sv
module tb_manhattan_distance;

    localparam int DIM = 3;
    localparam int DR  = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  axis;
    logic [23:0] point;
    logic [23:0] center;
    logic [9:0]  dst;
    logic [7:0]  axis_dst;
    logic        dst_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: inputs seen at the previous edge and edges
    // since reset release.
    int          e_cnt;
    logic [23:0] prev_p, prev_c;
    logic [1:0]  prev_a;
    int          exp_dst, exp_axd;
    logic        exp_done;

    manhattan_distance #(
        .dim        (DIM),
        .data_range (DR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .axis     (axis),
        .point    (point),
        .center   (center),
        .dst      (dst),
        .axis_dst (axis_dst),
        .dst_done (dst_done)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pk(input int c0, input int c1, input int c2);
        logic [7:0] b0, b1, b2;
        b0 = 8'(c0); b1 = 8'(c1); b2 = 8'(c2);
        return {b2, b1, b0};
    endfunction

    function automatic int coord(input logic [23:0] v, input int i);
        return int'((v >> (8 * i)) & 24'hff);
    endfunction

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int l1(input logic [23:0] p, input logic [23:0] c);
        int s = 0;
        for (int i = 0; i < DIM; i++) s += absdiff(coord(p, i), coord(c, i));
        return s;
    endfunction

    function automatic int axd(input logic [23:0] p, input logic [23:0] c, input logic [1:0] a);
`ifdef MANHATTAN_AXIS_DST_EN
        if (int'(a) < DIM) return absdiff(coord(p, int'(a)), coord(c, int'(a)));
        return 0;
`else
        return 0;
`endif
    endfunction

    // Apply inputs, take one edge, update model expectations, settle 1 time unit.
    task automatic advance(input logic [23:0] p, input logic [23:0] c, input logic [1:0] a);
        point = p; center = c; axis = a;
        @(posedge clk);
        if (e_cnt == 0) begin
            exp_dst = 0; exp_axd = 0; exp_done = 1'b0;
        end else begin
            exp_dst  = l1(prev_p, prev_c);
            exp_axd  = axd(prev_p, prev_c, prev_a);
            exp_done = (p == prev_p) && (c == prev_c) && (a == prev_a);
        end
        prev_p = p; prev_c = c; prev_a = a;
        e_cnt++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; point = '0; center = '0; axis = '0;
        e_cnt = 0;
        #12;
        n_tests++; if (dst !== 10'd0) begin n_fail++; $display("FAIL reset_dst: got %0d expected 0", dst); end
        n_tests++; if (axis_dst !== 8'd0) begin n_fail++; $display("FAIL reset_axis_dst: got %0d expected 0", axis_dst); end
        n_tests++; if (dst_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", dst_done); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_basic();
        advance(pk(10, 20, 30), pk(15, 10, 30), 2'd1);
        n_tests++; if (dst_done !== 1'b0) begin n_fail++; $display("FAIL basic_edge1_done: got %0b expected 0", dst_done); end
        n_tests++; if (dst !== 10'(exp_dst)) begin n_fail++; $display("FAIL basic_edge1_dst: got %0d expected %0d", dst, exp_dst); end
        advance(pk(10, 20, 30), pk(15, 10, 30), 2'd1);
        n_tests++; if (dst !== 10'(exp_dst)) begin n_fail++; $display("FAIL basic_dst: got %0d expected %0d", dst, exp_dst); end
        n_tests++; if (axis_dst !== 8'(exp_axd)) begin n_fail++; $display("FAIL basic_axis_dst: got %0d expected %0d", axis_dst, exp_axd); end
        n_tests++; if (dst_done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %0b expected 1", dst_done); end
    endtask

    task automatic test_extremes();
        logic [23:0] hi, lo;
        hi = pk(255, 255, 255); lo = pk(0, 0, 0);
        for (int s = 0; s < 2; s++) begin
            advance(s == 0 ? hi : lo, s == 0 ? lo : hi, 2'd2);
            advance(s == 0 ? hi : lo, s == 0 ? lo : hi, 2'd2);
            n_tests++; if (dst !== 10'(exp_dst)) begin n_fail++; $display("FAIL extreme_dst[%0d]: got %0d expected %0d", s, dst, exp_dst); end
            n_tests++; if (axis_dst !== 8'(exp_axd)) begin n_fail++; $display("FAIL extreme_axis_dst[%0d]: got %0d expected %0d", s, axis_dst, exp_axd); end
            n_tests++; if (dst_done !== exp_done) begin n_fail++; $display("FAIL extreme_done[%0d]: got %0b expected %0b", s, dst_done, exp_done); end
        end
    endtask

    task automatic test_center_change();
        advance(pk(10, 20, 30), pk(15, 10, 30), 2'd0);
        advance(pk(10, 20, 30), pk(15, 10, 30), 2'd0);
        advance(pk(10, 20, 30), pk(10, 20, 30), 2'd0);
        n_tests++; if (dst_done !== 1'b0) begin n_fail++; $display("FAIL cchg_m_done: got %0b expected 0", dst_done); end
        n_tests++; if (dst !== 10'(exp_dst)) begin n_fail++; $display("FAIL cchg_m_dst: got %0d expected %0d", dst, exp_dst); end
        advance(pk(10, 20, 30), pk(10, 20, 30), 2'd0);
        n_tests++; if (dst !== 10'(exp_dst)) begin n_fail++; $display("FAIL cchg_m1_dst: got %0d expected %0d", dst, exp_dst); end
        n_tests++; if (dst_done !== 1'b1) begin n_fail++; $display("FAIL cchg_m1_done: got %0b expected 1", dst_done); end
    endtask

    task automatic test_axis_only();
        advance(pk(40, 90, 7), pk(100, 60, 200), 2'd0);
        advance(pk(40, 90, 7), pk(100, 60, 200), 2'd0);
        n_tests++; if (axis_dst !== 8'(exp_axd)) begin n_fail++; $display("FAIL axis0_axis_dst: got %0d expected %0d", axis_dst, exp_axd); end
        advance(pk(40, 90, 7), pk(100, 60, 200), 2'd3);
        n_tests++; if (dst_done !== 1'b0) begin n_fail++; $display("FAIL axis3_done_drop: got %0b expected 0", dst_done); end
        n_tests++; if (dst !== 10'(exp_dst)) begin n_fail++; $display("FAIL axis3_dst_hold: got %0d expected %0d", dst, exp_dst); end
        advance(pk(40, 90, 7), pk(100, 60, 200), 2'd3);
        n_tests++; if (axis_dst !== 8'd0) begin n_fail++; $display("FAIL axis3_axis_dst: got %0d expected 0", axis_dst); end
        n_tests++; if (dst !== 10'(exp_dst)) begin n_fail++; $display("FAIL axis3_dst: got %0d expected %0d", dst, exp_dst); end
        n_tests++; if (dst_done !== 1'b1) begin n_fail++; $display("FAIL axis3_done: got %0b expected 1", dst_done); end
    endtask

    task automatic test_async_reset();
        logic [23:0] p, c;
        p = pk(200, 3, 77); c = pk(1, 250, 77);
        advance(p, c, 2'd1);
        advance(p, c, 2'd1);
        #2 rst = 1'b0;
        #1;
        n_tests++; if (dst !== 10'd0) begin n_fail++; $display("FAIL arst_dst: got %0d expected 0", dst); end
        n_tests++; if (axis_dst !== 8'd0) begin n_fail++; $display("FAIL arst_axis_dst: got %0d expected 0", axis_dst); end
        n_tests++; if (dst_done !== 1'b0) begin n_fail++; $display("FAIL arst_done: got %0b expected 0", dst_done); end
        #3 rst = 1'b1;
        e_cnt = 0;
        advance(p, c, 2'd1);
        n_tests++; if (dst_done !== 1'b0) begin n_fail++; $display("FAIL arst_edge1_done: got %0b expected 0", dst_done); end
        n_tests++; if (dst !== 10'd0) begin n_fail++; $display("FAIL arst_edge1_dst: got %0d expected 0", dst); end
        advance(p, c, 2'd1);
        n_tests++; if (dst_done !== 1'b1) begin n_fail++; $display("FAIL arst_edge2_done: got %0b expected 1", dst_done); end
        n_tests++; if (dst !== 10'(exp_dst)) begin n_fail++; $display("FAIL arst_edge2_dst: got %0d expected %0d", dst, exp_dst); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] p, c;
        for (int i = 0; i < 20; i++) begin
            p = pk(i * 11, 255 - i, i * 3);
            c = 24'($urandom);
            advance(p, c, 2'($urandom_range(0, 3)));
            n_tests++; if (dst_done !== 1'b0) begin n_fail++; $display("FAIL b2b_done[%0d]: got %0b expected 0", i, dst_done); end
            n_tests++; if (dst !== 10'(exp_dst)) begin n_fail++; $display("FAIL b2b_dst[%0d]: got %0d expected %0d", i, dst, exp_dst); end
            n_tests++; if (axis_dst !== 8'(exp_axd)) begin n_fail++; $display("FAIL b2b_axis_dst[%0d]: got %0d expected %0d", i, axis_dst, exp_axd); end
        end
    endtask

    task automatic test_random();
        logic [23:0] p, c;
        logic [1:0]  a;
        p = 24'($urandom); c = 24'($urandom); a = 2'($urandom);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 2))
                    0: p = 24'($urandom);
                    1: c = 24'($urandom);
                    default: a = 2'($urandom);
                endcase
            end
            advance(p, c, a);
            n_tests++; if (dst !== 10'(exp_dst)) begin n_fail++; $display("FAIL rand_dst[%0d]: got %0d expected %0d", i, dst, exp_dst); end
            n_tests++; if (axis_dst !== 8'(exp_axd)) begin n_fail++; $display("FAIL rand_axis_dst[%0d]: got %0d expected %0d", i, axis_dst, exp_axd); end
            n_tests++; if (dst_done !== exp_done) begin n_fail++; $display("FAIL rand_done[%0d]: got %0b expected %0b", i, dst_done, exp_done); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_center_change();
        test_axis_only();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/manhattan_distance.md
# manhattan_distance

Pipelined distance unit for the k-d tree clustering engine. Computes the L1 (Manhattan) distance between an input point and a cluster center, and also the absolute distance along one selected split axis. Instantiated inside each cluster compare element, where `axis_dst` drives the subtree-pruning decision and `dst` drives nearest-center selection. Runs continuously with no start strobe; `dst_done` reports when the outputs match the current inputs.

## Interface
Parameters:
- `dim`, default 3: number of coordinates per point.
- `data_range`, default 255: maximum coordinate value.
- Derived widths: `dim_size = $clog2(data_range)` (8), `center_size = dim*dim_size` (24), `dist_size = $clog2(data_range*dim)` (10), `axis_size = $clog2(dim)` (2).

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `axis`, in, `axis_size`: selected split axis.
- `point`, in, `center_size`: query point; coordinate i is `point[i*dim_size +: dim_size]`, so coordinate 0 is in the LSBs.
- `center`, in, `center_size`: cluster center; same packing as `point`.
- `dst`, out, `dist_size`: sum over i of |point_i − center_i|.
- `axis_dst`, out, `dim_size`: |point_axis − center_axis|.
- `dst_done`, out, 1: high when `dst` and `axis_dst` correspond to the current inputs.

## Operation
- Coordinates are unsigned. Each absolute difference is computed as larger minus smaller, so there is no signed arithmetic and no overflow within `dim_size` bits.
- Sum width: `dist_size` holds `dim*data_range` exactly (765 < 1024). No saturation logic is required.
- `axis >= dim` (for example 3 when `dim` = 3): `axis_dst` = 0. `dst` is unaffected.
- Stage A register: per-coordinate absolute differences, selected-axis difference, an input copy `in_q` = {axis, point, center}, and a `primed` flag (set to 1 on the first edge after reset).
- Stage B register:
  - `dst` ← sum of the Stage A differences.
  - `axis_dst` ← the Stage A axis difference.
  - `dst_done` ← `primed` && ({axis, point, center} == `in_q`).
- Reset (asserted at any time, including mid-computation): all registers clear. `dst`, `axis_dst`, `dst_done`, `primed` and `in_q` are all 0. Results in flight are discarded.

## Timing
- Latency is 2 edges. Inputs held before edge k produce `dst`/`axis_dst` after edge k+1.
- First edge after reset release: `dst_done` stays 0. It goes to 1 after the second edge if the inputs did not change between the two edges.
- Input change sampled at edge m:
  - `dst_done` is 0 after edge m, while `dst` still shows the old result.
  - If the inputs are held, `dst_done` returns to 1 after edge m+1, together with the new result.
- Continuous input changes on every edge keep `dst_done` at 0. Outputs still track the inputs with 2-edge latency.
- A change in `axis` alone also drops `dst_done` for one cycle.

## Configuration
- Macro `MANHATTAN_AXIS_DST_EN`.
  - Defined: `axis_dst` is computed as specified.
  - Undefined: the axis selection and its registers are removed, and `axis_dst` is tied to 0. `dst` and `dst_done` are unchanged. `axis` is still compared into `in_q` so that `dst_done` behaves identically in both builds.

## Structure
- Shared package `kd_pkg`:
  - width functions/constants: `dim_size`, `center_size`, `dist_size`, `axis_size`;
  - a coordinate-extract helper using the LSB-first packing.
  - `cluster_CE` and the tree logic use the same package.
- One sub-module, `abs_diff`: combinational |a−b| on `dim_size` bits, instantiated `dim` times. The selected-axis difference is a mux over these instances, not an extra subtractor.
- The adder is a plain combinational sum inside Stage B.

## Test plan
Parameters `dim`=3, `data_range`=255; coordinates are listed as (c0,c1,c2).
- Reset, then hold point=(10,20,30), center=(15,10,30), axis=1 → after edge 2: `dst`=15, `axis_dst`=10, `dst_done`=1. After edge 1: `dst_done`=0.
- Extremes: point=(255,255,255), center=(0,0,0), axis=2 → `dst`=765, `axis_dst`=255. Swapping point and center gives the same result.
- Change center to (10,20,30) while holding point=(10,20,30) → after edge m: `dst_done`=0, `dst`=15. After edge m+1: `dst`=0, `dst_done`=1.
- Hold point/center, change only `axis` 0→3 → `dst` unchanged, `axis_dst`=0, `dst_done` low for one cycle.
- Assert `rst` low mid-stream, asynchronously between edges → all outputs 0 immediately. After release, `dst_done` returns only after 2 edges.
- Build without `MANHATTAN_AXIS_DST_EN` → `axis_dst` is always 0; `dst` and `dst_done` sequences match the first scenario.
